// File: rtl/data_memory_responder.sv
// Word-addressed data memory responder for the datapath load/store port.
// Each access completes after Wait_States extra cycles with a one-cycle Ready pulse.
module data_memory_responder #(
  parameter int Data_Size    = 32,
  parameter int Address_Size = 32,
  parameter int Memory_Depth = 64,
  parameter int Wait_States  = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Req,
  input  logic                    Mem_Write,
  input  logic [Address_Size-1:0] Addr,
  input  logic [Data_Size-1:0]    WData,
  output logic [Data_Size-1:0]    RData,
  output logic                    Ready,
  output logic                    Busy,
  output logic                    Addr_Err
);

  localparam int IDX_W = $clog2(Memory_Depth);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [Address_Size-1:0] lat_addr;
  logic [Data_Size-1:0]    lat_wdata;
  logic                    lat_write;
  logic [Data_Size-1:0]    mem [Memory_Depth];

  logic [IDX_W-1:0] idx;
  logic             addr_bad;

  // Upper address bits only feed the range check, so nothing aliases modulo depth.
  assign idx      = lat_addr[IDX_W+1:2];
  assign addr_bad = (lat_addr[1:0] != 2'b00) || (|lat_addr[Address_Size-1:IDX_W+2]);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      RData     <= '0;
      Ready     <= 1'b0;
      Busy      <= 1'b0;
      Addr_Err  <= 1'b0;
      // NOTE: the array must come up zeroed, so it is built from resettable
      // flops rather than a RAM macro; reset also aborts any in-flight store.
      for (int i = 0; i < Memory_Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      Ready    <= 1'b0;
      Addr_Err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            lat_addr  <= Addr;
            lat_wdata <= WData;
            lat_write <= Mem_Write;
            cnt       <= 4'(Wait_States);
            Busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            Ready <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
            if (addr_bad) begin
              RData    <= '0;
              Addr_Err <= 1'b1;
            end else if (lat_write) begin
              mem[idx] <= lat_wdata;
            end else begin
              RData <= mem[idx];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Word-addressed data memory that serves load/store requests from the processor datapath. It is the responder end of the datapath's memory interface: it takes the ALU address and the store data, and returns read data. Accesses complete after a configurable number of wait states. A Busy output lets the control unit stall the program counter while an access is in flight.

Parameters:
Data_Size, 32, width of data words.
Address_Size, 32, width of the byte address from the ALU.
Memory_Depth, 64, number of words stored. Must be a power of two, 2..1024.
Wait_States, 2, extra cycles before an access completes. Range 0..15.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RST  input  1  reset; synchronous, active-low. Sampled on the rising CLK edge.
Req  input  1  request strobe; a single-cycle pulse per access.
Mem_Write  input  1  1 = store, 0 = load; sampled with Req.
Addr  input  Address_Size  byte address; sampled with Req.
WData  input  Data_Size  store data; sampled with Req.
RData  output  Data_Size  load data; registered.
Ready  output  1  one-cycle completion pulse; registered.
Busy  output  1  high while an access is in flight; registered.
Addr_Err  output  1  completion with an error; pulses together with Ready.

Behaviour:
- Reset (RST=0 at a rising edge):
  - state=IDLE, wait counter=0.
  - RData=0, Ready=0, Busy=0, Addr_Err=0.
  - All Memory_Depth words cleared to 0.
  - Reset has priority over every other event.
- States: IDLE, WAIT.
- IDLE, Req=1 at edge T0 (accept):
  - Latch Addr, WData and Mem_Write.
  - Load the counter with Wait_States.
  - Busy<=1, state<=WAIT.
- IDLE, Req=0: remain in IDLE, Busy=0.
- WAIT, counter≠0: decrement the counter each edge.
- WAIT, counter=0 (access edge, T0+Wait_States+1):
  - Perform the access.
  - Ready<=1, Busy<=0, state<=IDLE.
  - Ready drops to 0 at the following edge.
- Latency: Ready is high in exactly one cycle, the one after edge T0+Wait_States+1. With Wait_States=0, Ready is high in the cycle after T0+1.
- Word index = Addr[log2(Memory_Depth)+1:2].
- Error condition: Addr[1:0]≠0, or Addr[Address_Size-1:2] ≥ Memory_Depth. On error at the access edge:
  - No memory write.
  - RData<=0.
  - Addr_Err<=1 together with Ready.
- Load: RData<=mem[index] at the access edge. RData holds until the next load or error completion.
- Store: mem[index]<=latched WData at the access edge. RData is unchanged.
- Req while Busy=1 is ignored: no queueing, no state change.
- Req during the Ready cycle is accepted as a new request (state is IDLE). Back-to-back throughput is one access per Wait_States+2 cycles.
- Store then load to the same address back-to-back: the load returns the newly stored data.
- Reset in WAIT, including at the access edge: the access is aborted, no write is committed, and Ready does not pulse.
- Address width: upper address bits are used only for the range check. Nothing wraps modulo Memory_Depth.

Test Plan:
- Reset with RST=0 for 2 cycles → RData=0, Ready=0, Busy=0, Addr_Err=0; a load from 0x00 returns 0x00000000.
- Wait_States=2: store 0xDEADBEEF to 0x10 at T0 → Busy=1 for T0+1..T0+3, Ready in the cycle after T0+3. Load from 0x10 in the Ready cycle → RData=0xDEADBEEF with Ready 3 edges later.
- Misaligned load from 0x12, then out-of-range store to 0x100 (Memory_Depth=64) → each gives Ready=Addr_Err=1 and RData=0. A later load from 0x100 - 4 = 0xFC returns its prior contents, so nothing was corrupted.
- Req pulsed while Busy=1 with a store of 0x1 to 0x20 → ignored; exactly one Ready for the original request; a load from 0x20 returns 0.
- Wait_States=0: store 0x12345678 to 0x04, then load 0x04 back-to-back → Ready pulses at T0+1 and T0+3; RData=0x12345678.
- RST=0 asserted at the access edge of a store of 0xAAAA5555 to 0x08 → no Ready; a following load from 0x08 returns 0.
